// File: rtl/module_banco_registros_pkg.sv
// rtl/module_banco_registros_pkg.sv - shared limits and width helper for the register bank
// Purpose: parameter limits and the count-width helper used by the bank and its interface.
// Ports: none (package).
package banco_pkg;

  localparam int WIDTH_MAX = 32;
  localparam int DEPTH_MAX = 32;

  // Width needed to hold a count of 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/module_banco_registros_if.sv
// rtl/module_banco_registros_if.sv - write/read/clear bus of the register bank
// Purpose: groups the bank's write, clear, dual read and count signals.
// Ports (signals): we_i, waddr_i, wdata_i, clr_i, raddr_a_i, raddr_b_i (master -> bank),
//   rdata_a_o, rdata_b_o, rvalid_a_o, rvalid_b_o, count_o (bank -> master).
// Modports: master (datapath/bench side), slave (bank side).
interface module_banco_registros_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
);
  import banco_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic             we_i;
  logic [AW-1:0]    waddr_i;
  logic [WIDTH-1:0] wdata_i;
  logic             clr_i;
  logic [AW-1:0]    raddr_a_i;
  logic [AW-1:0]    raddr_b_i;
  logic [WIDTH-1:0] rdata_a_o;
  logic [WIDTH-1:0] rdata_b_o;
  logic             rvalid_a_o;
  logic             rvalid_b_o;
  logic [CW-1:0]    count_o;

  modport master (
    output we_i, waddr_i, wdata_i, clr_i, raddr_a_i, raddr_b_i,
    input  rdata_a_o, rdata_b_o, rvalid_a_o, rvalid_b_o, count_o
  );

  modport slave (
    input  we_i, waddr_i, wdata_i, clr_i, raddr_a_i, raddr_b_i,
    output rdata_a_o, rdata_b_o, rvalid_a_o, rvalid_b_o, count_o
  );

endinterface

// File: rtl/module_banco_registros_reg_ce.sv
// rtl/module_banco_registros_reg_ce.sv - WIDTH-bit register with clock enable
// Purpose: one storage entry of the bank; loads i_d when i_en is high.
// Ports: clk, rst_n (async active-low), i_en (load strobe), i_d (data in), o_q (stored data).
module module_reg_ce #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/module_banco_registros.sv
// rtl/module_banco_registros.sv - DEPTH x WIDTH register bank with valid flags and two read ports
// Purpose: one write port, two registered read ports, per-entry valid flags, bulk clear and
//   a live count of valid entries.
// Ports: clk, rst_n (async active-low), bus (module_banco_registros_if.slave).
// Option: BANCO_BYPASS_EN - when defined, a read of the address being written in the same
//   cycle (write not cancelled by clear) returns the new data with rvalid=1.
module module_banco_registros
  import banco_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  module_banco_registros_if.slave        bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [DEPTH-1:0] w_we;
  logic [WIDTH-1:0] w_q [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [CW-1:0]    r_count;
  logic             w_new;

  logic [WIDTH-1:0] w_rdata_a, w_rdata_b;
  logic             w_rvalid_a, w_rvalid_b;
  logic [WIDTH-1:0] r_rdata_a, r_rdata_b;
  logic             r_rvalid_a, r_rvalid_b;

  // Decoded write strobes; clear suppresses the write and out-of-range addresses match nothing.
  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    assign w_we[g] = bus.we_i && !bus.clr_i && (bus.waddr_i == AW'(g));

    module_reg_ce #(.WIDTH(WIDTH)) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_we[g]),
      .i_d   (bus.wdata_i),
      .o_q   (w_q[g])
    );
  end

  // Counter only moves when a write lands on a previously invalid entry, so it cannot pass DEPTH.
  assign w_new = |(w_we & ~r_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_count <= '0;
    end else if (bus.clr_i) begin
      r_valid <= '0;
      r_count <= '0;
    end else begin
      r_valid <= r_valid | w_we;
      if (w_new) begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  // Read muxes compare against each entry index so out-of-range addresses fall through to zero.
  always_comb begin
    w_rdata_a  = '0;
    w_rvalid_a = 1'b0;
    w_rdata_b  = '0;
    w_rvalid_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.raddr_a_i == AW'(i)) begin
        w_rdata_a  = w_q[i];
        w_rvalid_a = r_valid[i];
      end
      if (bus.raddr_b_i == AW'(i)) begin
        w_rdata_b  = w_q[i];
        w_rvalid_b = r_valid[i];
      end
    end
`ifdef BANCO_BYPASS_EN
    // |w_we already implies we_i, no clear and an in-range write address.
    if (|w_we && (bus.raddr_a_i == bus.waddr_i)) begin
      w_rdata_a  = bus.wdata_i;
      w_rvalid_a = 1'b1;
    end
    if (|w_we && (bus.raddr_b_i == bus.waddr_i)) begin
      w_rdata_b  = bus.wdata_i;
      w_rvalid_b = 1'b1;
    end
`else
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata_a  <= '0;
      r_rdata_b  <= '0;
      r_rvalid_a <= 1'b0;
      r_rvalid_b <= 1'b0;
    end else begin
      r_rdata_a  <= w_rdata_a;
      r_rdata_b  <= w_rdata_b;
      r_rvalid_a <= w_rvalid_a;
      r_rvalid_b <= w_rvalid_b;
    end
  end

  assign bus.rdata_a_o  = r_rdata_a;
  assign bus.rdata_b_o  = r_rdata_b;
  assign bus.rvalid_a_o = r_rvalid_a;
  assign bus.rvalid_b_o = r_rvalid_b;
  assign bus.count_o    = r_count;

endmodule

// File: doc/module_banco_registros.md
Name: module_banco_registros

Overview:
- Parametrised register bank, successor to the single 4-bit clock-enabled register.
- DEPTH entries of WIDTH bits, one write port, two independently addressed registered read ports.
- Each entry carries a valid flag; bulk clear; live count of valid entries.
- Sits between the switch/input datapath and the display/ALU consumers; runs directly on the board clock.

Parameters:
- WIDTH, 4, data bits per entry (1..32).
- DEPTH, 8, number of entries (2..32, need not be a power of two).
- AW, $clog2(DEPTH), address width; derived, never overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- we_i  input  1  write enable.
- waddr_i  input  AW  write address.
- wdata_i  input  WIDTH  write data.
- clr_i  input  1  synchronous clear of all valid flags.
- raddr_a_i  input  AW  read address, port A.
- raddr_b_i  input  AW  read address, port B.
- rdata_a_o  output  WIDTH  registered read data, port A.
- rdata_b_o  output  WIDTH  registered read data, port B.
- rvalid_a_o  output  1  valid flag of the entry read on port A.
- rvalid_b_o  output  1  valid flag of the entry read on port B.
- count_o  output  $clog2(DEPTH+1)  number of entries with valid=1.

Behaviour:
- Reset (rst_n=0, asynchronous): all entries 0, all valid flags 0, rdata_*=0, rvalid_*=0, count_o=0. Outputs hold these values until the first rising edge after deassertion.
- Write: we_i=1 and waddr_i<DEPTH at a rising edge → entry[waddr_i]=wdata_i, valid[waddr_i]=1.
- count_o increments by 1 only if that entry was previously invalid. Rewriting a valid entry leaves count_o unchanged.
- Out-of-range write (waddr_i>=DEPTH): ignored; no state change.
- Clear: clr_i=1 → all valid flags 0 and count_o=0 at the next edge. Data contents are not modified.
- Clear and write in the same cycle: clear wins; the write is dropped.
- Read: 1-cycle latency. rdata_x_o and rvalid_x_o after edge n reflect raddr_x_i sampled at edge n, using the state before that edge's write or clear.
- Out-of-range read: rdata=0, rvalid=0.
- Reading an invalid entry returns its stored data with rvalid=0.
- Ports A and B are fully independent; the same address on both returns identical results.
- count_o is registered and updates on the same edge as the flags. It never exceeds DEPTH and never wraps.
- Read-during-write to the same address without the optional feature: returns the old data and old valid flag.

Optional Feature:
- Macro: BANCO_BYPASS_EN.
- Defined: a read address equal to an in-range waddr_i with we_i=1 and clr_i=0 in the same cycle returns wdata_i with rvalid=1 at the next edge (write-through forwarding). Applies to each port separately.
- Undefined: old-data semantics as described in Behaviour; no forwarding logic is generated.

Decomposition:
- Package banco_pkg holds:
  - WIDTH_MAX=32 and DEPTH_MAX=32 limit constants.
  - Function cnt_w(depth) returning $clog2(depth+1).
- Sub-module module_reg_ce: WIDTH-bit register with clock enable and async active-low reset.
  - Replaces the old per-bit flip-flop cells.
  - Instantiated once per entry; the enable is the decoded write strobe.
- Read muxes, valid flags and the counter stay in the top module.

Test Plan:
- Reset mid-operation: write 4'hA to entry 3, assert rst_n=0 between edges → all outputs 0 immediately; reading addr 3 after release gives rdata=0, rvalid=0.
- Write 4'h5 to entries 0,1,2 → count_o=3. Rewrite entry 1 with 4'hF → count_o stays 3. Read A=1, B=2 → 4'hF/1 and 4'h5/1 one cycle later.
- Fill all 8 entries → count_o=8. Further writes leave count_o=8 (no wrap).
- clr_i=1 together with we_i to entry 4 → count_o=0; a later read of addr 4 gives rvalid=0 and old data unchanged.
- DEPTH=6: write to addr 7 ignored, count_o unchanged; read addr 7 → rdata=0, rvalid=0.
- Same-cycle write 4'h9 to addr 2 (previously 4'h5) while reading addr 2 → 4'h5/1 without BANCO_BYPASS_EN, 4'h9/1 with it.
